// File: rtl/navic_prn_pkg.sv
// Shared constants and state encoding for the NavIC L1 PRN generator scheduler.
package navic_prn_pkg;

    localparam int unsigned CODE_LEN = 10230;
    localparam int unsigned R_W      = 55;
    localparam int unsigned C_W      = 5;
    localparam int unsigned PRN_W    = 6;
    localparam int unsigned EDGE_W   = 24;
    localparam int unsigned IDX_W    = 14;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StRun,
        StDone
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IdxW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // N_REQ is a power of two, so the index addition wraps naturally.
            cand = ptr_i + IdxW'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/prn_gen_sched.sv
// Shares one serial PRN generator among N_REQ channels: grant, fetch seeds, load,
// stream one code epoch under backpressure and capture its first/last chips.
module prn_gen_sched #(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned CODE_LEN = navic_prn_pkg::CODE_LEN,
    localparam int unsigned OwnW     = $clog2(N_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [navic_prn_pkg::PRN_W*N_REQ-1:0] req_prn,
    output logic [N_REQ-1:0]                      req_ready,
    output logic                                  tbl_rd,
    output logic [navic_prn_pkg::PRN_W-1:0]       tbl_addr,
    input  logic [navic_prn_pkg::R_W-1:0]         tbl_r0,
    input  logic [navic_prn_pkg::R_W-1:0]         tbl_r1,
    input  logic [navic_prn_pkg::C_W-1:0]         tbl_c,
    output logic                                  gen_load,
    output logic [navic_prn_pkg::R_W-1:0]         gen_r0,
    output logic [navic_prn_pkg::R_W-1:0]         gen_r1,
    output logic [navic_prn_pkg::C_W-1:0]         gen_c,
    output logic                                  gen_step,
    input  logic                                  gen_chip,
    output logic                                  chip_valid,
    input  logic                                  chip_ready,
    output logic                                  chip,
    output logic [navic_prn_pkg::IDX_W-1:0]       chip_idx,
    output logic [OwnW-1:0]                       owner,
    output logic                                  busy,
    output logic                                  done,
    output logic [navic_prn_pkg::EDGE_W-1:0]      first,
    output logic [navic_prn_pkg::EDGE_W-1:0]      last
);
    import navic_prn_pkg::*;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CODE_LEN - 1);

    sched_state_e      state_q, state_d;
    logic [OwnW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [EDGE_W-1:0] first_q, first_d, last_q, last_d;
    logic [EDGE_W-1:0] first_out_q, first_out_d, last_out_q, last_out_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [OwnW-1:0]   arb_idx;
    logic              arb_valid;
    logic [PRN_W-1:0]  prn_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_prn
        assign prn_arr[g] = req_prn[g*PRN_W +: PRN_W];
    end

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req_i  (req_valid),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        idx_d       = idx_q;
        first_d     = first_q;
        last_d      = last_q;
        first_out_d = first_out_q;
        last_out_d  = last_out_q;
        req_ready   = '0;
        tbl_rd      = 1'b0;
        tbl_addr    = '0;
        gen_load    = 1'b0;
        gen_r0      = '0;
        gen_r1      = '0;
        gen_c       = '0;
        gen_step    = 1'b0;
        chip_valid  = 1'b0;
        chip        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    req_ready = arb_gnt;
                    owner_d   = arb_idx;
                    tbl_rd    = 1'b1;
                    tbl_addr  = prn_arr[arb_idx];
                    rr_ptr_d  = arb_idx + OwnW'(1);
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                gen_load = 1'b1;
                gen_r0   = tbl_r0;
                gen_r1   = tbl_r1;
                gen_c    = tbl_c;
                idx_d    = '0;
                state_d  = StRun;
            end
            StRun: begin
                chip_valid = 1'b1;
                chip       = gen_chip;
                if (chip_ready) begin
                    gen_step = 1'b1;
                    if (idx_q < IDX_W'(EDGE_W)) begin
                        first_d[idx_q[4:0]] = gen_chip;
                    end
                    // Bit 0 holds the oldest of the trailing chips, bit 23 the newest.
                    last_d = {gen_chip, last_q[EDGE_W-1:1]};
                    if (idx_q == LastIdx) begin
                        idx_d       = '0;
                        first_out_d = first_d;
                        last_out_d  = last_d;
                        state_d     = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            idx_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            first_out_q <= '0;
            last_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            first_out_q <= first_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign chip_idx = idx_q;
    assign owner    = owner_q;
    assign busy     = (state_q != StIdle);
    assign first    = first_out_q;
    assign last     = last_out_q;

endmodule

// File: tb/tb_prn_gen_sched.sv
// Bench for prn_gen_sched: seed ROM and generator stand-ins, expected chip streams
// computed per PRN, directed epochs with random backpressure and a mid-run reset.
module tb_prn_gen_sched;
    import navic_prn_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CL = 10230;

    logic          clk_tb = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [6*N-1:0] req_prn;
    logic [N-1:0]  req_ready;
    logic          tbl_rd;
    logic [5:0]    tbl_addr;
    logic [54:0]   tbl_r0 = '0;
    logic [54:0]   tbl_r1 = '0;
    logic [4:0]    tbl_c  = '0;
    logic          gen_load;
    logic [54:0]   gen_r0, gen_r1;
    logic [4:0]    gen_c;
    logic          gen_step, gen_chip;
    logic          chip_valid, chip_ready, chip;
    logic [13:0]   chip_idx;
    logic [1:0]    owner;
    logic          busy, done;
    logic [23:0]   first, last;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit          exp_chips [CL];
    logic [23:0] exp_first, exp_last;

    always #5 clk_tb = ~clk_tb;
    always @(posedge clk_tb) cyc <= cyc + 1;

    prn_gen_sched #(
        .N_REQ   (N),
        .CODE_LEN(CL)
    ) dut (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_prn   (req_prn),
        .req_ready (req_ready),
        .tbl_rd    (tbl_rd),
        .tbl_addr  (tbl_addr),
        .tbl_r0    (tbl_r0),
        .tbl_r1    (tbl_r1),
        .tbl_c     (tbl_c),
        .gen_load  (gen_load),
        .gen_r0    (gen_r0),
        .gen_r1    (gen_r1),
        .gen_c     (gen_c),
        .gen_step  (gen_step),
        .gen_chip  (gen_chip),
        .chip_valid(chip_valid),
        .chip_ready(chip_ready),
        .chip      (chip),
        .chip_idx  (chip_idx),
        .owner     (owner),
        .busy      (busy),
        .done      (done),
        .first     (first),
        .last      (last)
    );

    function automatic logic [54:0] seed_r0(input logic [5:0] p);
        if (p == 6'd0) return 55'o0227743641272102303;
        return 55'h12_3456_789A_BCDE ^ {p, 49'd0} ^ {49'd0, p};
    endfunction

    function automatic logic [54:0] seed_r1(input logic [5:0] p);
        if (p == 6'd0) return 55'o1667217344450257245;
        return 55'h2A5A_5A5A_5A5A_5A ^ {3'd0, p, 46'd0} ^ {43'd0, p, 6'd0};
    endfunction

    function automatic logic [4:0] seed_c(input logic [5:0] p);
        if (p == 6'd0) return 5'b01000;
        return p[4:0] ^ 5'b10101;
    endfunction

    // Stand-in PRN core: three feedback shift registers, chip is the XOR of their MSBs.
    function automatic logic [114:0] gen_next(input logic [114:0] s);
        logic [54:0] r0, r1;
        logic [4:0]  c;
        {r0, r1, c} = s;
        return {r0[53:0], r0[54] ^ r0[53] ^ r0[49] ^ r0[20],
                r1[53:0], r1[54] ^ r1[30] ^ r1[7] ^ r1[0],
                c[3:0], c[4] ^ c[2]};
    endfunction

    function automatic logic gen_out(input logic [114:0] s);
        return s[114] ^ s[59] ^ s[4];
    endfunction

    logic [114:0] g_state = '0;
    assign gen_chip = gen_out(g_state);

    always @(posedge clk_tb) begin
        if (tbl_rd) begin
            tbl_r0 <= seed_r0(tbl_addr);
            tbl_r1 <= seed_r1(tbl_addr);
            tbl_c  <= seed_c(tbl_addr);
        end
        if (gen_load)      g_state <= {gen_r0, gen_r1, gen_c};
        else if (gen_step) g_state <= gen_next(g_state);
    end

    task automatic build_exp(input logic [5:0] prn);
        logic [114:0] s;
        s = {seed_r0(prn), seed_r1(prn), seed_c(prn)};
        for (int i = 0; i < CL; i++) begin
            exp_chips[i] = gen_out(s);
            s = gen_next(s);
        end
        for (int i = 0; i < 24; i++) begin
            exp_first[i] = exp_chips[i];
            exp_last[i]  = exp_chips[CL - 24 + i];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        vectors++;
        assert ({req_ready, tbl_rd, tbl_addr, gen_load, gen_r0, gen_r1, gen_c, gen_step,
                 chip_valid, chip, chip_idx, owner, busy, done} === '0)
        else begin
            miscompares++;
            $error("FAIL %s_outputs: rdy=%b rd=%b addr=%0d load=%b step=%b cv=%b idx=%0d own=%0d busy=%b done=%b, want all 0",
                   tag, req_ready, tbl_rd, tbl_addr, gen_load, gen_step, chip_valid,
                   chip_idx, owner, busy, done);
        end
        vectors++;
        assert (first === 24'd0 && last === 24'd0)
        else begin
            miscompares++;
            $error("FAIL %s_edges: first=%h last=%h, want 0 0", tag, first, last);
        end
    endtask

    // Runs one epoch for channel ch from grant to DONE (or to chip abort_at when >= 0).
    // Entered after a posedge; returns at the negedge of the DONE (or abort) cycle.
    task automatic run_epoch(input int ch, input logic [5:0] prn, input bit stall,
                             input int abort_at, output int t_grant, output int t_done);
        int k, chip_err, idx_err, strobe_err, steps, stalls, budget;
        bit granted, fin, aborted;
        build_exp(prn);
        k = 0; chip_err = 0; idx_err = 0; strobe_err = 0; steps = 0; stalls = 0; budget = 0;
        granted = 1'b0; fin = 1'b0; aborted = 1'b0; t_grant = -1; t_done = -1;
        while (!fin && budget < 3 * CL + 100) begin
            @(negedge clk_tb);
            budget++;
            if (!granted) begin
                if (req_ready != '0) begin
                    granted = 1'b1;
                    t_grant = cyc;
                    vectors++;
                    assert (req_ready === (N'(1) << ch) && tbl_rd === 1'b1 && tbl_addr === prn)
                    else begin
                        miscompares++;
                        $error("FAIL grant_ch%0d: ready=%b rd=%b addr=%0d, want ready=%b rd=1 addr=%0d",
                               ch, req_ready, tbl_rd, tbl_addr, N'(1) << ch, prn);
                    end
                end
            end else if (cyc == t_grant + 1) begin
                vectors++;
                assert (gen_load === 1'b1 && gen_r0 === seed_r0(prn) && gen_r1 === seed_r1(prn)
                        && gen_c === seed_c(prn) && gen_step === 1'b0 && busy === 1'b1)
                else begin
                    miscompares++;
                    $error("FAIL load_ch%0d: load=%b r0=%o r1=%o c=%b, want load=1 r0=%o r1=%o c=%b",
                           ch, gen_load, gen_r0, gen_r1, gen_c, seed_r0(prn), seed_r1(prn),
                           seed_c(prn));
                end
            end else begin
                if (gen_load !== 1'b0 || req_ready !== '0 || tbl_rd !== 1'b0) strobe_err++;
                if (owner !== 2'(ch) || busy !== 1'b1) strobe_err++;
                if (chip_valid === 1'b1 && chip_ready === 1'b1) begin
                    if (k < CL && chip !== exp_chips[k]) chip_err++;
                    if (chip_idx !== 14'(k)) idx_err++;
                    if (gen_step !== 1'b1) strobe_err++;
                    steps++;
                    k++;
                end else begin
                    if (gen_step !== 1'b0) strobe_err++;
                    if (chip_valid === 1'b1) stalls++;
                end
                if (abort_at >= 0 && chip_valid === 1'b1 && chip_idx == 14'(abort_at)) begin
                    fin = 1'b1;
                    aborted = 1'b1;
                end
                if (done === 1'b1) begin
                    fin = 1'b1;
                    t_done = cyc;
                end
            end
            if (!fin) begin
                @(posedge clk_tb);
                #1;
                if (granted) req_valid[ch] = 1'b0;
                chip_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        vectors++;
        assert (fin) else begin
            miscompares++;
            $error("FAIL timeout_ch%0d: epoch not finished after %0d cycles, want finished",
                   ch, budget);
        end
        vectors++;
        assert (strobe_err == 0) else begin
            miscompares++;
            $error("FAIL strobes_ch%0d: %0d bad strobe/owner/busy cycles, want 0", ch, strobe_err);
        end
        if (!aborted) begin
            vectors++;
            assert (chip_err == 0 && k == CL) else begin
                miscompares++;
                $error("FAIL chips_ch%0d: %0d wrong of %0d accepted, want 0 of %0d",
                       ch, chip_err, k, CL);
            end
            vectors++;
            assert (idx_err == 0) else begin
                miscompares++;
                $error("FAIL chip_idx_ch%0d: %0d wrong indices, want 0", ch, idx_err);
            end
            vectors++;
            assert (steps == CL) else begin
                miscompares++;
                $error("FAIL gen_steps_ch%0d: %0d, want %0d", ch, steps, CL);
            end
            vectors++;
            assert (first === exp_first && last === exp_last) else begin
                miscompares++;
                $error("FAIL edges_ch%0d: first=%h last=%h, want %h %h",
                       ch, first, last, exp_first, exp_last);
            end
            vectors++;
            assert (t_done - t_grant == CL + 2 + stalls) else begin
                miscompares++;
                $error("FAIL latency_ch%0d: %0d cycles, want %0d",
                       ch, t_done - t_grant, CL + 2 + stalls);
            end
        end
    endtask

    initial begin
        int tg, td, idle_err;
        int tgs [N];
        int tds [N];
        logic [5:0] prns [N];
        prns[0] = 6'd3; prns[1] = 6'd10; prns[2] = 6'd36; prns[3] = 6'd63;

        rst_n = 1'b0; req_valid = '0; req_prn = '0; chip_ready = 1'b0;
        repeat (3) @(posedge clk_tb);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk_tb);
        #1;

        // Single PRN 0 epoch on ch0; ch1 raises and drops a request while it runs.
        chip_ready = 1'b1;
        req_prn[5:0] = 6'd0;
        req_valid[0] = 1'b1;
        fork
            run_epoch(0, 6'd0, 1'b0, -1, tg, td);
            begin
                repeat (100) @(posedge clk_tb);
                #2;
                req_valid[1] = 1'b1;
                repeat (20) @(posedge clk_tb);
                #2;
                req_valid[1] = 1'b0;
            end
        join
        idle_err = 0;
        repeat (6) begin
            @(negedge clk_tb);
            if (req_ready !== '0 || tbl_rd !== 1'b0) idle_err++;
        end
        vectors++;
        assert (idle_err == 0 && busy === 1'b0) else begin
            miscompares++;
            $error("FAIL dropped_req: %0d grant/read cycles busy=%b, want 0 and busy=0",
                   idle_err, busy);
        end

        // ch1 (rr_ptr now 1) aborted by reset at chip 5000.
        @(posedge clk_tb);
        #1;
        req_prn[11:6] = 6'd10;
        req_valid[1] = 1'b1;
        run_epoch(1, 6'd10, 1'b0, 5000, tg, td);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_run_reset");
        @(posedge clk_tb);
        #1;
        rst_n = 1'b1;

        // Fresh epoch after reset under random backpressure.
        req_prn[23:18] = 6'd36;
        req_valid[3] = 1'b1;
        run_epoch(3, 6'd36, 1'b1, -1, tg, td);

        // All four channels at once; rr_ptr wrapped to 0.
        @(posedge clk_tb);
        #1;
        chip_ready = 1'b1;
        for (int i = 0; i < N; i++) req_prn[6*i +: 6] = prns[i];
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            run_epoch(i, prns[i], 1'b0, -1, tgs[i], tds[i]);
        end
        for (int i = 1; i < N; i++) begin
            vectors++;
            assert (tgs[i] == tds[i-1] + 1) else begin
                miscompares++;
                $error("FAIL back_to_back_ch%0d: grant at %0d, want %0d", i, tgs[i], tds[i-1] + 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
